dot_product_stream: RTL and testbench

Streaming dot-product engine that computes the dot product of two LEN-element vectors, A and B, delivered serially on one input port (A then B). It is the parametrised successor of the fixed 3-element, 8-bit dot-product block. Differences from that block: configurable width and length, valid/ready handshake on input and output, a held result with backpressure, and an optional signed mode. It sits between a sample-stream producer and any consumer of scalar results, such as a filter or correlator stage.

---
 rtl/dot_product_stream_if.sv | 27 ++
 rtl/dot_product_stream.sv | 115 +++++++++++
 tb/tb_dot_product_stream.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_stream_if.sv
// rtl/dot_product_stream_if.sv - operand/result stream bundle for dot_product_stream
interface dot_product_stream_if #(
   parameter int DATA_W = 8,
   parameter int LEN    = 3
);
   localparam int OUT_W = 2*DATA_W + $clog2(LEN);

   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic [OUT_W-1:0]  dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              run;

   // The dot-product engine consumes operands and produces results
   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, run
   );

   // The producer/consumer side drives operands and accepts results
   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, run
   );
endinterface

// File: rtl/dot_product_stream.sv
// rtl/dot_product_stream.sv - streaming LEN-element dot product, A then B on one port
// Optional signed operands/result when DOT_PRODUCT_STREAM_SIGNED_EN is defined.
module dot_product_stream #(
   parameter int DATA_W = 8,
   parameter int LEN    = 3
) (
   input logic                  clk,
   input logic                  resetn,
   dot_product_stream_if.slave  dp
);
   localparam int OUT_W = 2*DATA_W + $clog2(LEN);
   localparam int IDX_W = $clog2(LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN-1);

   typedef enum logic {LOAD_A, LOAD_B} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [OUT_W-1:0]   dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic [DATA_W-1:0]  a_buf [LEN];

   logic               idx_last;
   logic               accept;
   logic [DATA_W-1:0]  a_sel;
   logic [2*DATA_W-1:0] prod;
   logic [OUT_W-1:0]   prod_ext;

   assign idx_last = (idx_q == IDX_LAST);
   assign a_sel    = a_buf[idx_q];

   // Stall only the final B beat while an unconsumed result would be overwritten
   assign dp.din_ready = !((state_q == LOAD_B) && idx_last && dout_valid_q && !dp.dout_ready);
   assign accept       = dp.din_valid && dp.din_ready;

`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
   assign prod     = $signed({{DATA_W{a_sel[DATA_W-1]}}, a_sel}) *
                     $signed({{DATA_W{dp.din[DATA_W-1]}}, dp.din});
   assign prod_ext = {{(OUT_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
   assign prod     = {{DATA_W{1'b0}}, a_sel} * {{DATA_W{1'b0}}, dp.din};
   assign prod_ext = {{(OUT_W-2*DATA_W){1'b0}}, prod};
`endif

   assign dp.dout       = dout_q;
   assign dp.dout_valid = dout_valid_q;
   assign dp.run        = (state_q == LOAD_A) && (idx_q == '0);

   // State, index, accumulator and result registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= LOAD_A;
         idx_q        <= '0;
         acc_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // A-vector capture; contents are don't-care until rewritten, so no reset
   always_ff @(posedge clk) begin
      if (accept && (state_q == LOAD_A)) begin
         a_buf[idx_q] <= dp.din;
      end
   end

   // Next-state: load A, then multiply-accumulate B and publish on the last beat
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;

      if (dout_valid_q && dp.dout_ready) begin
         dout_valid_d = 1'b0;
      end

      if (accept) begin
         case (state_q)
            LOAD_A: begin
               if (idx_last) begin
                  state_d = LOAD_B;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            LOAD_B: begin
               if (idx_last) begin
                  state_d      = LOAD_A;
                  idx_d        = '0;
                  acc_d        = '0;
                  dout_d       = acc_q + prod_ext;
                  dout_valid_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  acc_d = acc_q + prod_ext;
               end
            end
            default: begin
               state_d = LOAD_A;
               idx_d   = '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dot_product_stream.sv
// tb/tb_dot_product_stream.sv - directed self-checking bench for dot_product_stream
module tb_dot_product_stream;
   localparam int DATA_W = 8;
   localparam int LEN    = 3;
   localparam int OUT_W  = 2*DATA_W + $clog2(LEN);
   localparam int NB     = 2*LEN;

   typedef logic [DATA_W-1:0] vec_t [NB];

   logic clk = 1'b0;
   logic resetn = 1'b0;

   dot_product_stream_if #(.DATA_W(DATA_W), .LEN(LEN)) dp ();

   dot_product_stream #(.DATA_W(DATA_W), .LEN(LEN)) dut (
      .clk    (clk),
      .resetn (resetn),
      .dp     (dp)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: current pair's operands, expected held result and its valid flag
   vec_t             m_ops;
   int               m_cnt   = 0;
   bit               m_valid = 1'b0;
   logic [OUT_W-1:0] m_dout  = '0;

   function automatic logic [OUT_W-1:0] model_dot(input vec_t v);
      longint sum = 0;
      for (int i = 0; i < LEN; i++) begin
`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
         sum += longint'($signed(v[i])) * longint'($signed(v[LEN+i]));
`else
         sum += longint'(v[i]) * longint'(v[LEN+i]);
`endif
      end
      return OUT_W'(sum);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Compare every cycle, then advance the reference by the edge that follows
   always @(negedge clk) begin : monitor
      bit exp_ready;
      exp_ready = !((m_cnt == NB-1) && m_valid && !dp.dout_ready);
      chk("din_ready", longint'(dp.din_ready), longint'(exp_ready));
      chk("run", longint'(dp.run), longint'(m_cnt == 0));
      chk("dout_valid", longint'(dp.dout_valid), longint'(m_valid));
      chk("dout", longint'(dp.dout), longint'(m_dout));
      if (!resetn) begin
         m_cnt   = 0;
         m_valid = 1'b0;
         m_dout  = '0;
      end else begin
         if (m_valid && dp.dout_ready) m_valid = 1'b0;
         if (dp.din_valid && exp_ready) begin
            m_ops[m_cnt] = dp.din;
            if (m_cnt == NB-1) begin
               m_dout  = model_dot(m_ops);
               m_valid = 1'b1;
               m_cnt   = 0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] v);
      bit ok = 1'b0;
      dp.din       = v;
      dp.din_valid = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = dp.din_ready;
         tick();
      end
      dp.din_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got din_ready=0 for 50 cycles expected acceptance");
      end
   endtask

   task automatic send_vec(input vec_t v, input bit bubbles);
      for (int i = 0; i < NB; i++) begin
         send(v[i]);
         if (bubbles && i < NB-1) tick();
      end
   endtask

   vec_t v_basic, v_max, v_ones, v_twos, v_s1, v_s2;
   longint exp_max;

   initial begin
      v_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      v_max   = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      v_ones  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
      v_twos  = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
      v_s1    = '{8'hFF, 8'h80, 8'h02, 8'h03, 8'h80, 8'hFE};
      v_s2    = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h01};
`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
      exp_max = 3;
`else
      exp_max = 195075;
`endif

      dp.din        = '0;
      dp.din_valid  = 1'b0;
      dp.dout_ready = 1'b0;
      resetn        = 1'b0;
      repeat (3) tick();
      chk("rst_run", longint'(dp.run), 1);
      chk("rst_dout_valid", longint'(dp.dout_valid), 0);
      chk("rst_dout", longint'(dp.dout), 0);
      chk("rst_din_ready", longint'(dp.din_ready), 1);
      resetn = 1'b1;

      chk("model_basic", longint'(model_dot(v_basic)), 32);
      chk("model_max", longint'(model_dot(v_max)), exp_max);
      chk("model_ones", longint'(model_dot(v_ones)), 3);

      // Back-to-back basic vector
      dp.dout_ready = 1'b1;
      send_vec(v_basic, 1'b0);
      chk("basic_valid", longint'(dp.dout_valid), 1);
      chk("basic_dout", longint'(dp.dout), 32);
      chk("basic_run", longint'(dp.run), 1);
      tick();
      chk("basic_consumed", longint'(dp.dout_valid), 0);

      // Largest operands
      send_vec(v_max, 1'b0);
      chk("max_valid", longint'(dp.dout_valid), 1);
      chk("max_dout", longint'(dp.dout), exp_max);
      tick();

      // Backpressure on the final B beat
      dp.dout_ready = 1'b0;
      send_vec(v_basic, 1'b0);
      chk("bp_first_dout", longint'(dp.dout), 32);
      for (int i = 0; i < NB-1; i++) send(8'd1);
      dp.din       = 8'd1;
      dp.din_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("bp_stall", longint'(dp.din_ready), 0);
         tick();
      end
      chk("bp_hold_valid", longint'(dp.dout_valid), 1);
      chk("bp_hold_dout", longint'(dp.dout), 32);
      dp.dout_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", longint'(dp.din_ready), 1);
      tick();
      dp.dout_ready = 1'b0;
      dp.din_valid  = 1'b0;
      chk("bp_second_valid", longint'(dp.dout_valid), 1);
      chk("bp_second_dout", longint'(dp.dout), 3);
      tick();
      chk("bp_second_held", longint'(dp.dout), 3);
      dp.dout_ready = 1'b1;
      tick();
      chk("bp_drained", longint'(dp.dout_valid), 0);

      // Bubbles between every beat
      send_vec(v_basic, 1'b1);
      chk("bubble_valid", longint'(dp.dout_valid), 1);
      chk("bubble_dout", longint'(dp.dout), 32);
      tick();

      // Reset with a pending result and a partial pair
      dp.dout_ready = 1'b0;
      send_vec(v_twos, 1'b0);
      chk("rstmid_pending", longint'(dp.dout), 12);
      for (int i = 0; i < 4; i++) send(8'd9);
      resetn = 1'b0;
      tick();
      chk("rstmid_valid", longint'(dp.dout_valid), 0);
      chk("rstmid_dout", longint'(dp.dout), 0);
      chk("rstmid_run", longint'(dp.run), 1);
      tick();
      resetn        = 1'b1;
      dp.dout_ready = 1'b1;
      send_vec(v_basic, 1'b0);
      chk("rstmid_after_valid", longint'(dp.dout_valid), 1);
      chk("rstmid_after_dout", longint'(dp.dout), 32);
      tick();

`ifdef DOT_PRODUCT_STREAM_SIGNED_EN
      chk("model_signed1", longint'(model_dot(v_s1)), 16377);
      chk("model_signed2", longint'(model_dot(v_s2)), 262141);
      send_vec(v_s1, 1'b0);
      chk("signed1_dout", longint'(dp.dout), 16377);
      tick();
      send_vec(v_s2, 1'b0);
      chk("signed2_dout", longint'(dp.dout), 262141);
      tick();
`else
      chk("model_unsigned_s2", longint'(model_dot(v_s2)), 765);
      send_vec(v_s2, 1'b0);
      chk("unsigned_s2_dout", longint'(dp.dout), 765);
      tick();
`endif

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
